// File: rtl/scan_com_pkg.sv
// rtl/scan_com_pkg.sv - COM codes, slot and FSM types shared by the scan/COM driver and decoder
package scan_com_pkg;

   localparam logic [3:0] COM_DIGIT1 = 4'b0010;
   localparam logic [3:0] COM_DIGIT2 = 4'b0001;

   typedef enum logic [1:0] {NONE, S1, S2} slot_e;

   typedef enum logic [1:0] {WAIT, SETTLE, HOLD, ILLEGAL} state_e;

   function automatic slot_e decode_slot(input logic [3:0] com);
      slot_e slot;
      case (com)
         COM_DIGIT1: slot = S1;
         COM_DIGIT2: slot = S2;
         default:    slot = NONE;
      endcase
      return slot;
   endfunction

endpackage

// File: rtl/scan_sync.sv
// rtl/scan_sync.sv - multi-stage input synchronizer, parameterised width and depth, resets to 0
module scan_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_pipe [STAGES];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/scan_com_decoder.sv
// rtl/scan_com_decoder.sv - demultiplexes the scan/COM display bus into two digit registers
// Optional stale-bus timeout enabled by defining SCAN_TIMEOUT_EN.
module scan_com_decoder
   import scan_com_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 4
`ifdef SCAN_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic       sysClk,
   input  logic       sysRstN,
   input  logic [3:0] COM,
   input  logic [3:0] boundedData,
   output logic [3:0] data1,
   output logic [3:0] data2,
   output logic       frameValid,
   output logic       comError,
   output logic       stale
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   logic [7:0]    w_sync;
   logic [3:0]    w_com_s;
   logic [3:0]    w_data_s;
   logic [7:0]    r_prev;
   slot_e         w_slot;
   logic          w_change;
   state_e        r_state;
   state_e        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_reach;
   logic          w_capture;
   logic          w_illegal_hit;
   logic          w_frame;
   logic          w_timeout_hit;
   logic [3:0]    r_shadow1;
   logic [3:0]    r_shadow2;
   logic [3:0]    r_data1;
   logic [3:0]    r_data2;
   logic          r_seen1;
   logic          r_seen2;
   logic          r_frame_valid;
   logic          r_com_error;

   scan_sync #(
      .WIDTH  (8),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk   (sysClk),
      .i_rst_n (sysRstN),
      .i_d     ({COM, boundedData}),
      .o_q     (w_sync)
   );

   assign w_com_s  = w_sync[7:4];
   assign w_data_s = w_sync[3:0];
   assign w_slot   = decode_slot(w_com_s);
   assign w_change = (w_sync != r_prev);
   assign w_frame  = r_seen1 && r_seen2;

   always_ff @(posedge sysClk or negedge sysRstN) begin
      if (!sysRstN) r_state <= WAIT;
      else          r_state <= w_state_nxt;
   end

   // The change sample counts as the first of SETTLE_CYCLES identical samples.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_reach       = 1'b0;
      w_capture     = 1'b0;
      w_illegal_hit = 1'b0;
      if (w_change) begin
         w_cnt_nxt   = CW'(1);
         w_state_nxt = (w_slot == NONE) ? ILLEGAL : SETTLE;
      end else if ((r_state == SETTLE || r_state == ILLEGAL) && r_cnt != CW'(SETTLE_CYCLES)) begin
         w_cnt_nxt = r_cnt + CW'(1);
      end
      w_reach = (w_state_nxt == SETTLE || w_state_nxt == ILLEGAL) &&
                (w_cnt_nxt == CW'(SETTLE_CYCLES)) && (w_change || r_cnt != w_cnt_nxt);
      if (w_reach) begin
         if (w_state_nxt == SETTLE) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
         end else begin
            w_illegal_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge sysClk or negedge sysRstN) begin
      if (!sysRstN) begin
         r_prev        <= '0;
         r_cnt         <= '0;
         r_shadow1     <= '0;
         r_shadow2     <= '0;
         r_data1       <= '0;
         r_data2       <= '0;
         r_seen1       <= 1'b0;
         r_seen2       <= 1'b0;
         r_frame_valid <= 1'b0;
         r_com_error   <= 1'b0;
      end else begin
         r_prev        <= w_sync;
         r_cnt         <= w_cnt_nxt;
         r_frame_valid <= w_frame;
         r_com_error   <= w_illegal_hit;
         if (w_capture && w_slot == S1) r_shadow1 <= w_data_s;
         if (w_capture && w_slot == S2) r_shadow2 <= w_data_s;
         if (w_frame) begin
            r_data1 <= r_shadow1;
            r_data2 <= r_shadow2;
         end
         r_seen1 <= (r_seen1 && !w_frame && !w_timeout_hit) || (w_capture && w_slot == S1);
         r_seen2 <= (r_seen2 && !w_frame && !w_timeout_hit) || (w_capture && w_slot == S2);
      end
   end

`ifdef SCAN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_to_cnt;
   logic [TW-1:0] w_to_cnt_nxt;
   logic          r_stale;

   always_comb begin
      w_to_cnt_nxt = r_to_cnt;
      if (w_capture)                            w_to_cnt_nxt = '0;
      else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) w_to_cnt_nxt = r_to_cnt + TW'(1);
   end

   assign w_timeout_hit = !w_capture && (w_to_cnt_nxt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge sysClk or negedge sysRstN) begin
      if (!sysRstN) begin
         r_to_cnt <= '0;
         r_stale  <= 1'b0;
      end else begin
         r_to_cnt <= w_to_cnt_nxt;
         if (w_frame)            r_stale <= 1'b0;
         else if (w_timeout_hit) r_stale <= 1'b1;
      end
   end

   assign stale = r_stale;
`else
   assign w_timeout_hit = 1'b0;
   assign stale         = 1'b0;
`endif

   assign data1      = r_data1;
   assign data2      = r_data2;
   assign frameValid = r_frame_valid;
   assign comError   = r_com_error;

endmodule

// File: tb/tb_scan_com_decoder.sv
// tb/tb_scan_com_decoder.sv - directed self-checking bench for scan_com_decoder
module tb_scan_com_decoder;

`ifdef SCAN_TIMEOUT_EN
   localparam int SEG = 12;
`else
   localparam int SEG = 20;
`endif

   logic       sysClk = 1'b0;
   logic       sysRstN;
   logic [3:0] COM;
   logic [3:0] boundedData;
   logic [3:0] data1;
   logic [3:0] data2;
   logic       frameValid;
   logic       comError;
   logic       stale;

   int total = 0;
   int bad   = 0;

   always #5 sysClk = ~sysClk;

   scan_com_decoder #(
      .SYNC_STAGES   (2),
      .SETTLE_CYCLES (4)
`ifdef SCAN_TIMEOUT_EN
      , .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .sysClk      (sysClk),
      .sysRstN     (sysRstN),
      .COM         (COM),
      .boundedData (boundedData),
      .data1       (data1),
      .data2       (data2),
      .frameValid  (frameValid),
      .comError    (comError),
      .stale       (stale)
   );

   task automatic tick();
      @(posedge sysClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycle i is i clock edges after the input change; 0 means no pulse expected.
   task automatic run_check(input string tag, input int n, input int fv_at, input int ce_at);
      for (int i = 1; i <= n; i++) begin
         tick();
         check($sformatf("%s_fv_c%0d", tag, i), {7'd0, frameValid}, {7'd0, (i == fv_at)});
         check($sformatf("%s_ce_c%0d", tag, i), {7'd0, comError},   {7'd0, (i == ce_at)});
      end
   endtask

   task automatic drive(input logic [3:0] com, input logic [3:0] dat);
      COM         = com;
      boundedData = dat;
   endtask

   initial begin
      sysRstN = 1'b0;
      drive(4'h0, 4'h0);

      // reset with random inputs
      for (int i = 0; i < 3; i++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         tick();
      end
      check("rst_data1", {4'd0, data1}, 8'h00);
      check("rst_data2", {4'd0, data2}, 8'h00);
      check("rst_fv",    {7'd0, frameValid}, 8'h00);
      check("rst_ce",    {7'd0, comError}, 8'h00);
      check("rst_stale", {7'd0, stale}, 8'h00);
      drive(4'h0, 4'h0);
      tick();
      sysRstN = 1'b1;
      tick();

      // normal frame
      drive(4'b0010, 4'h7);
      run_check("frm_s1", SEG, 0, 0);
      check("frm_mid_data1", {4'd0, data1}, 8'h00);
      drive(4'b0001, 4'hA);
      run_check("frm_s2", SEG, 7, 0);
      check("frm_data1", {4'd0, data1}, 8'h07);
      check("frm_data2", {4'd0, data2}, 8'h0A);

      // short glitch to digit2 during digit1
      drive(4'b0010, 4'h7);
      run_check("gl_s1", 12, 0, 0);
      drive(4'b0001, 4'h5);
      run_check("gl_pulse", 2, 0, 0);
      drive(4'b0010, 4'h7);
      run_check("gl_back", 12, 0, 0);
      check("gl_data1", {4'd0, data1}, 8'h07);
      check("gl_data2", {4'd0, data2}, 8'h0A);

      // illegal COM code
      drive(4'b0011, 4'h7);
      run_check("ill", 10, 0, 6);
      check("ill_data1", {4'd0, data1}, 8'h07);
      check("ill_data2", {4'd0, data2}, 8'h0A);

      // reset during slot2 settling
      drive(4'b0001, 4'h3);
      tick();
      tick();
      sysRstN = 1'b0;
      tick();
      tick();
      check("mrst_data1", {4'd0, data1}, 8'h00);
      check("mrst_data2", {4'd0, data2}, 8'h00);
      check("mrst_fv",    {7'd0, frameValid}, 8'h00);
      check("mrst_ce",    {7'd0, comError}, 8'h00);
      sysRstN = 1'b1;
      run_check("mrst_s2", 12, 0, 0);
      check("mrst_s2_data2", {4'd0, data2}, 8'h00);
      drive(4'b0010, 4'h9);
      run_check("mrst_s1", SEG, 7, 0);
      check("mrst_data1_new", {4'd0, data1}, 8'h09);
      check("mrst_data2_new", {4'd0, data2}, 8'h03);

`ifdef SCAN_TIMEOUT_EN
      // stale after 16 capture-free cycles, cleared by the next frame
      drive(4'b0010, 4'h4);
      for (int i = 1; i <= 24; i++) begin
         tick();
         check($sformatf("to_fv_c%0d", i), {7'd0, frameValid}, 8'h00);
         check($sformatf("to_stale_c%0d", i), {7'd0, stale}, {7'd0, (i >= 22)});
      end
      drive(4'b0001, 4'h6);
      run_check("to_s2", 12, 0, 0);
      check("to_stale_hold", {7'd0, stale}, 8'h01);
      drive(4'b0010, 4'h8);
      run_check("to_s1", 12, 7, 0);
      check("to_stale_clr", {7'd0, stale}, 8'h00);
      check("to_data1", {4'd0, data1}, 8'h08);
      check("to_data2", {4'd0, data2}, 8'h06);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
